pwm_generator_multi: RTL and testbench

- Parametrised multi-channel successor to the single-channel PWM generator with increase/decrease duty control.
- N_CH independent PWM outputs share one period counter.
- Each channel has debounced increase/decrease inputs, a configurable step size, saturation at 0 and 100%, and glitch-free duty updates at period boundaries.
- Sits between the button/control logic and the power-stage or LED drivers.

---
 rtl/pwm_generator_multi.sv | 158 +++++++++++++++
 tb/tb_pwm_generator_multi.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_generator_multi.sv
// Multi-channel PWM generator: shared period counter, debounced inc/dec per channel.
// Define PWM_DEADTIME_EN to add complementary PWM_OUT_N outputs with dead-band.
module pwm_generator_multi #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int PERIOD     = 100,
  parameter int STEP       = 10,
  parameter int INIT_DUTY  = 50,
  parameter int DEB_CYCLES = 4,
  parameter int DEAD_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         increase_duty,
  input  logic [N_CH-1:0]         decrease_duty,
  output logic [N_CH-1:0]         PWM_OUT,
`ifdef PWM_DEADTIME_EN
  output logic [N_CH-1:0]         PWM_OUT_N,
`endif
  output logic [N_CH*CNT_W-1:0]   duty_o,
  output logic                    period_tick
);

  localparam int DB_W  = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam int RUN_W = (DEAD_CYC < 2) ? 1 : $clog2(DEAD_CYC + 1);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] PER     = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] INIT    = CNT_W'(INIT_DUTY);
  localparam logic [CNT_W:0]   PER_X   = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   STEP_X  = (CNT_W+1)'(STEP);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEB_CYCLES - 1);
  localparam logic [RUN_W-1:0] DEAD_X  = RUN_W'(DEAD_CYC);

  if (PERIOD > (1 << CNT_W) - 1 || INIT_DUTY > PERIOD ||
      DEB_CYCLES < 1 || DEAD_CYC < 0 || PERIOD < 1) begin : g_bad_cfg
    $error("pwm_generator_multi: invalid parameter set");
  end

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_wrap;
  logic             r_tick;

  assign w_wrap      = (r_cnt == LAST);
  assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + CNT_W'(1);
  assign period_tick = r_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= w_wrap;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       w_raw;
    logic [1:0]       w_rise;
    logic [CNT_W-1:0] r_tgt;
    logic [CNT_W-1:0] r_act;
    logic [CNT_W-1:0] w_tgt_nxt;
    logic [CNT_W:0]   w_up;
    logic             r_pwm;

    assign w_raw = {decrease_duty[i], increase_duty[i]};

    for (genvar j = 0; j < 2; j++) begin : g_in
      logic            r_s1;
      logic            r_s2;
      logic            r_deb;
      logic [DB_W-1:0] r_dcnt;

      // Step request fires on the edge where the debounced level goes high.
      assign w_rise[j] = r_s2 && !r_deb && (r_dcnt == DB_LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1   <= 1'b0;
          r_s2   <= 1'b0;
          r_deb  <= 1'b0;
          r_dcnt <= '0;
        end else begin
          r_s1 <= w_raw[j];
          r_s2 <= r_s1;
          if (r_s2 == r_deb) begin
            r_dcnt <= '0;
          end else if (r_dcnt == DB_LAST) begin
            r_deb  <= r_s2;
            r_dcnt <= '0;
          end else begin
            r_dcnt <= r_dcnt + DB_W'(1);
          end
        end
      end
    end

    assign w_up = {1'b0, r_tgt} + STEP_X;

    always_comb begin
      w_tgt_nxt = r_tgt;
      case (w_rise)
        2'b01: w_tgt_nxt = (w_up > PER_X) ? PER : w_up[CNT_W-1:0];
        2'b10: w_tgt_nxt = ({1'b0, r_tgt} < STEP_X) ? '0
                         : r_tgt - STEP_X[CNT_W-1:0];
        default: w_tgt_nxt = r_tgt;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_tgt <= INIT;
        r_act <= INIT;
      end else begin
        r_tgt <= w_tgt_nxt;
        if (w_wrap) r_act <= r_tgt;
      end
    end

`ifdef PWM_DEADTIME_EN
    logic             w_p;
    logic [RUN_W-1:0] r_hi;
    logic [RUN_W-1:0] r_lo;
    logic             r_pwm_n;

    assign w_p = (r_cnt < r_act);

    // Run counters saturate at DEAD_CYC; an output only rises once its phase
    // of p has already lasted that long, so short phases are swallowed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_hi    <= '0;
        r_lo    <= '0;
        r_pwm   <= 1'b0;
        r_pwm_n <= 1'b0;
      end else begin
        r_hi    <= !w_p ? '0 : (r_hi == DEAD_X) ? r_hi : r_hi + RUN_W'(1);
        r_lo    <=  w_p ? '0 : (r_lo == DEAD_X) ? r_lo : r_lo + RUN_W'(1);
        r_pwm   <=  w_p && (r_hi == DEAD_X);
        r_pwm_n <= !w_p && (r_lo == DEAD_X);
      end
    end

    assign PWM_OUT_N[i] = r_pwm_n;
`else
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pwm <= 1'b0;
      else     r_pwm <= (r_cnt < r_act);
    end
`endif

    assign PWM_OUT[i]                  = r_pwm;
    assign duty_o[i*CNT_W +: CNT_W]    = r_tgt;
  end

endmodule

// File: tb/tb_pwm_generator_multi.sv
// Bench for pwm_generator_multi: directed + random presses against a period-level model.
// The model tracks per-channel target/active duty and expected waveform per cycle.
module tb_pwm_generator_multi;

  localparam int N_CH       = 4;
  localparam int CNT_W      = 8;
  localparam int PERIOD     = 100;
  localparam int STEP       = 10;
  localparam int INIT_DUTY  = 50;
  localparam int DEB_CYCLES = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       inc;
  logic [N_CH-1:0]       dec;
  logic [N_CH-1:0]       pwm;
  logic [N_CH*CNT_W-1:0] duty;
  logic                  tick;
`ifdef PWM_DEADTIME_EN
  logic [N_CH-1:0]       pwm_n;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;
  int m_tgt [N_CH];
  int m_act [N_CH];
  int c;
  logic [N_CH-1:0] e;
  int r_ch, r_op, r_len;

  pwm_generator_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .STEP(STEP),
    .INIT_DUTY(INIT_DUTY), .DEB_CYCLES(DEB_CYCLES), .DEAD_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .increase_duty(inc),
    .decrease_duty(dec),
    .PWM_OUT(pwm),
`ifdef PWM_DEADTIME_EN
    .PWM_OUT_N(pwm_n),
`endif
    .duty_o(duty),
    .period_tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Clock edges since reset release; the counter phase is k mod PERIOD.
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  // Phase 0 shows the last slot of the finished period; phases 1..d are
  // the d high slots of the period that just started.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) m_act[i] = INIT_DUTY;
    end else if (k > 0) begin
      c = k % PERIOD;
      for (int i = 0; i < N_CH; i++) begin
        if (c == 0) begin
          e[i]     = (PERIOD - 1 < m_act[i]);
          m_act[i] = m_tgt[i];
        end else begin
          e[i] = (c - 1 < m_act[i]);
        end
      end
      chk("pwm", pwm, e);
      chk("tick", tick, c == 0);
    end
  end

  function automatic int step_model(int t, bit up, bit dn);
    if (up && !dn) return (t + STEP > PERIOD) ? PERIOD : t + STEP;
    if (dn && !up) return (t < STEP) ? 0 : t - STEP;
    return t;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(int lo, int hi);
    @(negedge clk);
    for (int g = 0; g < PERIOD &&
         !((k % PERIOD) >= lo && (k % PERIOD) <= hi); g++)
      @(negedge clk);
  endtask

  task automatic check_duty(string tag);
    for (int i = 0; i < N_CH; i++)
      chk($sformatf("%s_duty%0d", tag, i), duty[i*CNT_W +: CNT_W], m_tgt[i]);
  endtask

  task automatic press(int ch, bit up, bit dn, int len,
                       int lo, int hi, string tag);
    wait_phase(lo, hi);
    inc[ch] = up;
    dec[ch] = dn;
    cyc(len);
    inc[ch] = 1'b0;
    dec[ch] = 1'b0;
    cyc(10);
    if (len >= DEB_CYCLES) m_tgt[ch] = step_model(m_tgt[ch], up, dn);
    check_duty(tag);
  endtask

  initial begin
    rst = 1'b1;
    inc = '0;
    dec = '0;
    for (int i = 0; i < N_CH; i++) begin
      m_tgt[i] = INIT_DUTY;
      m_act[i] = INIT_DUTY;
    end
    cyc(3);
    chk("rst_pwm", pwm, 0);
    chk("rst_tick", tick, 0);
    check_duty("rst0");
    #1 rst = 1'b0;

    cyc(2*PERIOD + 2);
    check_duty("idle");

    repeat (3) press(0, 1'b1, 1'b0, 10, 5, 60, "inc0");
    cyc(2*PERIOD);

    press(1, 1'b1, 1'b0, 2, 5, 70, "glitch1");
    press(1, 1'b1, 1'b0, 3, 5, 70, "short1");
    wait_phase(5, 70);
    inc[1] = 1'b1;
    cyc(12);
    m_tgt[1] = step_model(m_tgt[1], 1'b1, 1'b0);
    check_duty("hold_a");
    cyc(288);
    check_duty("hold_b");
    inc[1] = 1'b0;
    cyc(10);
    check_duty("hold_c");

    repeat (6) press(2, 1'b0, 1'b1, 10, 5, 70, "dec2");
    repeat (6) press(3, 1'b1, 1'b0, 10, 5, 70, "inc3");
    cyc(2*PERIOD);

    press(0, 1'b1, 1'b1, 10, 5, 70, "both0");
    press(0, 1'b0, 1'b1, 10, 20, 20, "mid0");
    cyc(2*PERIOD);

    repeat (24) begin
      r_ch  = $urandom_range(0, N_CH - 1);
      r_op  = $urandom_range(0, 2);
      r_len = $urandom_range(1, 12);
      press(r_ch, r_op != 1, r_op != 0, r_len, 5, 70, "rnd");
    end
    repeat (6) press(3, 1'b1, 1'b0, 6, 5, 70, "top3");
    cyc(PERIOD);

    wait_phase(37, 37);
    chk("pre_rst_pwm3", pwm[3], 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm", pwm, 0);
    chk("async_rst_tick", tick, 0);
    for (int i = 0; i < N_CH; i++) m_tgt[i] = INIT_DUTY;
    check_duty("async_rst");
    cyc(3);
    #1 rst = 1'b0;
    cyc(2*PERIOD + 5);
    check_duty("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
